data_bus_bridge: RTL and testbench
==================================

# data_bus_bridge

Converts the CPU core's single-cycle data SRAM port (en / byte-we / addr / wdata / rdata) into a valid/ready request/response bus with variable latency, and returns a stall to the core while an access is outstanding. It sits directly downstream of the CPU top's data SRAM interface and upstream of the data memory / bus interconnect. A single-entry posted write buffer lets the core continue past a store without waiting for the write response.

## Interface
- WBUF_EN, 1, 1 = posted single-entry write buffer; 0 = writes stall the core like reads
- RDATA_RST, 32'h0, reset value of cpu_rdata
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- cpu_en  in  1  data access request from the core
- cpu_we  in  4  byte write enables; 0 = read, nonzero = write
- cpu_addr  in  32  byte address, passed through unmodified
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid in the DONE cycle of a read
- cpu_stall  out  1  combinational; core holds its request while 1
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts the request
- req_wr  out  1  1 = write
- req_wstrb  out  4  byte strobes, equal to the captured cpu_we
- req_addr  out  32  captured address
- req_wdata  out  32  captured store data
- resp_valid  in  1  bus response valid
- resp_ready  out  1  bridge accepts the response
- resp_rdata  in  32  read data
- resp_err  in  1  bus error for this response
- bus_err  out  1  sticky error flag, cleared only by reset

## Operation
- States: IDLE, WREQ, WRESP, RREQ, RRESP, DONE. Request registers: wr, wstrb, addr, wdata.
- IDLE, cpu_en=1, cpu_we≠0:
  - Capture the request, go to WREQ.
  - If WBUF_EN=1: cpu_stall=0 in this cycle; the write is posted.
  - If WBUF_EN=0: cpu_stall=1.
- IDLE, cpu_en=1, cpu_we=0: capture the request, cpu_stall=1, go to RREQ.
- IDLE, cpu_en=0: stay in IDLE, cpu_stall=0.
- WREQ / RREQ:
  - req_valid=1, driven from registers and held stable.
  - On req_ready=1, go to WRESP / RRESP.
- WRESP / RRESP:
  - resp_ready=1.
  - On resp_valid=1, if resp_err=1, set bus_err.
  - RRESP latches resp_rdata into cpu_rdata and goes to DONE.
  - WRESP goes to IDLE if WBUF_EN=1, else to DONE.
- DONE: cpu_stall=0, go to IDLE. In this cycle the core consumes the result; its still-held request is not recaptured.
- In any state other than IDLE and DONE, cpu_stall = cpu_en. A new access issued while the write buffer drains therefore waits.
- resp_valid is ignored outside WRESP/RRESP. req_ready is ignored outside WREQ/RREQ.
- cpu_rdata holds its last value except on a RRESP capture. For writes it is unchanged.
- A resp_err read still returns resp_rdata to the core. The only error reporting is bus_err.

## Timing
- Reset values: state=IDLE, req_valid=0, resp_ready=0, req_* regs=0, cpu_rdata=RDATA_RST, bus_err=0.
- While reset=1: cpu_stall=0. Reset applies immediately, even mid-transaction; any outstanding bus transfer is abandoned.
- Minimum read latency (req_ready and resp_valid tied high), request at cycle t:
  - RREQ at t+1, RRESP at t+2, DONE at t+3.
  - cpu_stall=1 in cycles t..t+2 and 0 in t+3.
- Each bus wait cycle, on either channel, adds exactly one stall cycle.
- Posted write at cycle t: no stall at t. The buffer is busy t+1 until the WRESP handshake cycle. The next access is accepted in the IDLE cycle after that.
- Back-to-back accesses: at most one bus transaction is outstanding. There is no request/response overlap.
- req_* must not change while req_valid=1 and req_ready=0.

## Test plan
- Read, ready tied high:
  - Stimulus: addr=0x1C000100; resp_rdata=0x12345678 at t+2.
  - Required: stall high for 3 cycles; cpu_rdata=0x12345678 at t+3; req_wr=0.
- Posted store then immediate load:
  - Stimulus: store we=4'b0011, addr=0x100, wdata=0xAABBCCDD at t; load issued at t+1; req_ready held low 2 cycles.
  - Required: no stall at t; req_wstrb=4'b0011; load stalls until the write response; the load request appears only after WRESP.
- WBUF_EN=0 store:
  - Required: stall high through WREQ/WRESP; released in DONE; cpu_rdata unchanged.
- Backpressure:
  - Stimulus: req_ready low 5 cycles, resp_valid low 3 cycles.
  - Required: req_* stable throughout; stall extended by exactly 8 cycles.
- Error:
  - Stimulus: resp_err=1 on a read.
  - Required: bus_err=1 and stays 1 across later clean accesses until reset.
- Reset asserted in RRESP:
  - Required: immediate IDLE, req_valid=0, resp_ready=0, cpu_rdata=RDATA_RST, cpu_stall=0; the next read after deassertion completes normally.

Source files
------------

// File: rtl/data_bus_bridge.sv
// Bridges the core's single-cycle data SRAM port onto a valid/ready request/response bus.
// One access is outstanding at a time; stores may be posted through a single-entry buffer.
module data_bus_bridge #(
  parameter bit          WBUF_EN   = 1'b1,
  parameter logic [31:0] RDATA_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_wr,
  output logic [3:0]  req_wstrb,
  output logic [31:0] req_addr,
  output logic [31:0] req_wdata,
  input  logic        resp_valid,
  output logic        resp_ready,
  input  logic [31:0] resp_rdata,
  input  logic        resp_err,
  output logic        bus_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREQ,
    S_WRESP,
    S_RREQ,
    S_RRESP,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   capture;
  logic   rd_capture;
  logic   err_set;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, stall and capture strobes
  always_comb begin
    state_nxt  = state;
    cpu_stall  = 1'b0;
    capture    = 1'b0;
    rd_capture = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cpu_en) begin
          capture = 1'b1;
          if (cpu_we != SW'(0)) begin
            state_nxt = S_WREQ;
            cpu_stall = ~WBUF_EN;
          end else begin
            state_nxt = S_RREQ;
            cpu_stall = 1'b1;
          end
        end
      end
      S_WREQ: begin
        cpu_stall = cpu_en;
        if (req_ready) state_nxt = S_WRESP;
      end
      S_WRESP: begin
        cpu_stall = cpu_en;
        if (resp_valid) begin
          err_set   = resp_err;
          state_nxt = WBUF_EN ? S_IDLE : S_DONE;
        end
      end
      S_RREQ: begin
        cpu_stall = cpu_en;
        if (req_ready) state_nxt = S_RRESP;
      end
      S_RRESP: begin
        cpu_stall = cpu_en;
        if (resp_valid) begin
          err_set    = resp_err;
          rd_capture = 1'b1;
          state_nxt  = S_DONE;
        end
      end
      S_DONE: begin
        // Core consumes the result here; its held request must not be recaptured.
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (reset) cpu_stall = 1'b0;
  end

  // Registered bus-side outputs, request payload, load data and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_valid  <= 1'b0;
      resp_ready <= 1'b0;
      req_wr     <= 1'b0;
      req_wstrb  <= SW'(0);
      req_addr   <= AW'(0);
      req_wdata  <= DW'(0);
      cpu_rdata  <= RDATA_RST;
      bus_err    <= 1'b0;
    end else begin
      req_valid  <= (state_nxt == S_WREQ) || (state_nxt == S_RREQ);
      resp_ready <= (state_nxt == S_WRESP) || (state_nxt == S_RRESP);
      if (capture) begin
        req_wr    <= (cpu_we != SW'(0));
        req_wstrb <= cpu_we;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
      end
      if (rd_capture) cpu_rdata <= resp_rdata;
      if (err_set)    bus_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_data_bus_bridge.sv
// Directed self-checking bench for data_bus_bridge (posted-write and non-posted instances).
module tb_data_bus_bridge;

  logic        clk;
  logic        reset;
  logic        cpu_en;
  logic        en0;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic [31:0] cpu_rdata, rdata0;
  logic        cpu_stall, stall0;
  logic        req_valid, req_valid0;
  logic        req_wr, req_wr0;
  logic [3:0]  req_wstrb, req_wstrb0;
  logic [31:0] req_addr, req_addr0;
  logic [31:0] req_wdata, req_wdata0;
  logic        resp_ready, resp_ready0;
  logic        bus_err, bus_err0;

  int n_tests = 0;
  int n_fail  = 0;
  int nst;

  data_bus_bridge #(.WBUF_EN(1'b1), .RDATA_RST(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset), .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_wstrb(req_wstrb),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .bus_err(bus_err)
  );

  data_bus_bridge #(.WBUF_EN(1'b0), .RDATA_RST(32'hCAFEF00D)) dut0 (
    .clk(clk), .reset(reset), .cpu_en(en0), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rdata0), .cpu_stall(stall0),
    .req_valid(req_valid0), .req_ready(req_ready), .req_wr(req_wr0), .req_wstrb(req_wstrb0),
    .req_addr(req_addr0), .req_wdata(req_wdata0), .resp_valid(resp_valid),
    .resp_ready(resp_ready0), .resp_rdata(resp_rdata), .resp_err(resp_err), .bus_err(bus_err0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Minimum-latency read on the posted instance: stall t..t+2, data in DONE at t+3
  task automatic read_min(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic err);
    req_ready = 1'b1; resp_valid = 1'b1; resp_rdata = d; resp_err = err;
    cpu_en = 1'b1; cpu_we = 4'h0; cpu_addr = a;
    smp; chk({tag, "_stall_t0"}, 32'(cpu_stall), 32'd1);
    cyc; smp;
    chk({tag, "_stall_t1"}, 32'(cpu_stall), 32'd1);
    chk({tag, "_req_valid"}, 32'(req_valid), 32'd1);
    chk({tag, "_req_addr"}, req_addr, a);
    chk({tag, "_req_wr"}, 32'(req_wr), 32'd0);
    cyc; smp;
    chk({tag, "_stall_t2"}, 32'(cpu_stall), 32'd1);
    chk({tag, "_resp_ready"}, 32'(resp_ready), 32'd1);
    cyc; smp;
    chk({tag, "_stall_t3"}, 32'(cpu_stall), 32'd0);
    chk({tag, "_rdata"}, cpu_rdata, d);
    cyc;
    cpu_en = 1'b0; resp_err = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_en = 1'b1; en0 = 1'b0; cpu_we = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = 32'h0; resp_err = 1'b0;

    // Reset state
    smp;
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_resp_ready", 32'(resp_ready), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("rst_bus_err", 32'(bus_err), 32'd0);
    chk("rst_req_addr", req_addr, 32'h0);
    cyc; reset = 1'b0; cpu_en = 1'b0;
    smp; chk("idle_stall", 32'(cpu_stall), 32'd0);
    cyc;

    // Read, bus ready tied high
    read_min("rd", 32'h1C000100, 32'h12345678, 1'b0);

    // Posted store followed immediately by a load, req_ready low 2 cycles
    cpu_en = 1'b1; cpu_we = 4'b0011; cpu_addr = 32'h100; cpu_wdata = 32'hAABBCCDD;
    req_ready = 1'b0; resp_valid = 1'b1; resp_rdata = 32'h0BADF00D;
    smp; chk("st_nostall", 32'(cpu_stall), 32'd0);
    cyc; cpu_we = 4'h0; cpu_addr = 32'h200; cpu_wdata = 32'h0;
    smp;
    chk("st_ld_stall1", 32'(cpu_stall), 32'd1);
    chk("st_req_valid", 32'(req_valid), 32'd1);
    chk("st_req_wr", 32'(req_wr), 32'd1);
    chk("st_wstrb", 32'(req_wstrb), 32'h3);
    chk("st_req_addr", req_addr, 32'h100);
    chk("st_req_wdata", req_wdata, 32'hAABBCCDD);
    cyc; smp;
    chk("st_hold_valid", 32'(req_valid), 32'd1);
    chk("st_hold_addr", req_addr, 32'h100);
    chk("st_hold_wdata", req_wdata, 32'hAABBCCDD);
    chk("st_ld_stall2", 32'(cpu_stall), 32'd1);
    cyc; req_ready = 1'b1;
    smp; chk("st_ld_stall3", 32'(cpu_stall), 32'd1);
    cyc; smp;
    chk("st_wresp_ready", 32'(resp_ready), 32'd1);
    chk("st_wresp_noreq", 32'(req_valid), 32'd0);
    chk("st_ld_stall4", 32'(cpu_stall), 32'd1);
    cyc; smp;
    chk("ld_idle_noreq", 32'(req_valid), 32'd0);
    chk("ld_idle_stall", 32'(cpu_stall), 32'd1);
    cyc; smp;
    chk("ld_req_valid", 32'(req_valid), 32'd1);
    chk("ld_req_addr", req_addr, 32'h200);
    chk("ld_req_wr", 32'(req_wr), 32'd0);
    cyc; smp;
    chk("ld_rresp_stall", 32'(cpu_stall), 32'd1);
    cyc; smp;
    chk("ld_done_stall", 32'(cpu_stall), 32'd0);
    chk("ld_rdata", cpu_rdata, 32'h0BADF00D);
    cyc; cpu_en = 1'b0;

    // Non-posted store on the WBUF_EN=0 instance
    req_ready = 1'b1; resp_valid = 1'b1;
    en0 = 1'b1; cpu_we = 4'hF; cpu_addr = 32'h300; cpu_wdata = 32'h11223344;
    smp; chk("nb_stall_t0", 32'(stall0), 32'd1);
    cyc; smp;
    chk("nb_stall_wreq", 32'(stall0), 32'd1);
    chk("nb_req_valid", 32'(req_valid0), 32'd1);
    chk("nb_wstrb", 32'(req_wstrb0), 32'hF);
    cyc; smp;
    chk("nb_stall_wresp", 32'(stall0), 32'd1);
    chk("nb_resp_ready", 32'(resp_ready0), 32'd1);
    cyc; smp;
    chk("nb_done_stall", 32'(stall0), 32'd0);
    chk("nb_rdata_kept", rdata0, 32'hCAFEF00D);
    cyc; en0 = 1'b0; cpu_we = 4'h0;
    smp; chk("nb_idle_stall", 32'(stall0), 32'd0);
    cyc;

    // Backpressure: 5 req wait cycles, 3 resp wait cycles -> 11 stall cycles
    cpu_en = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h400; resp_rdata = 32'hFEEDC0DE;
    nst = 0;
    for (int k = 0; k < 12; k++) begin
      req_ready  = (k == 6);
      resp_valid = (k == 10);
      if (k == 1) cpu_addr = 32'h444;
      smp;
      if (cpu_stall) nst++;
      chk("bp_stall", 32'(cpu_stall), (k <= 10) ? 32'd1 : 32'd0);
      if (k >= 1 && k <= 6) begin
        chk("bp_req_valid", 32'(req_valid), 32'd1);
        chk("bp_req_addr", req_addr, 32'h400);
        chk("bp_req_wr", 32'(req_wr), 32'd0);
      end
      if (k >= 7 && k <= 10) chk("bp_resp_ready", 32'(resp_ready), 32'd1);
      if (k == 11) chk("bp_rdata", cpu_rdata, 32'hFEEDC0DE);
      cyc;
    end
    cpu_en = 1'b0;
    chk("bp_stall_cycles", 32'(nst), 32'd11);

    // Error on a read is sticky across later clean accesses
    read_min("err", 32'h500, 32'h55AA55AA, 1'b1);
    chk("err_set", 32'(bus_err), 32'd1);
    cpu_en = 1'b1; cpu_we = 4'b1000; cpu_addr = 32'h600; cpu_wdata = 32'h77000000;
    req_ready = 1'b1; resp_valid = 1'b1;
    cyc; cpu_en = 1'b0; cpu_we = 4'h0;
    cyc; cyc;
    smp; chk("err_after_wr", 32'(bus_err), 32'd1);
    cyc;
    read_min("clean", 32'h700, 32'h0F0F0F0F, 1'b0);
    chk("err_after_rd", 32'(bus_err), 32'd1);

    // Reset asserted while waiting in RRESP
    cpu_en = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h800; req_ready = 1'b1; resp_valid = 1'b0;
    cyc; cyc;
    smp; chk("mr_in_rresp", 32'(resp_ready), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_stall", 32'(cpu_stall), 32'd0);
    chk("mr_req_valid", 32'(req_valid), 32'd0);
    chk("mr_resp_ready", 32'(resp_ready), 32'd0);
    chk("mr_rdata", cpu_rdata, 32'hDEADBEEF);
    chk("mr_bus_err", 32'(bus_err), 32'd0);
    chk("mr_req_addr", req_addr, 32'h0);
    cpu_en = 1'b0;
    cyc; reset = 1'b0;
    smp; chk("mr_idle_stall", 32'(cpu_stall), 32'd0);
    cyc;
    read_min("post_rst", 32'h900, 32'h13579BDF, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
